mmio_io_controller: RTL
=======================

// Module: mmio_io_controller
// PURPOSE
//   Parametrised memory-mapped I/O controller between the single-cycle CPU data port and external SRAM.
//   Decodes a 16-word I/O window at the top of the address space into N_OUT writable output registers (LEDs),
//   N_IN debounced input ports (buttons/switches), sticky rising-edge flags and an interrupt mask.
//   Every address outside the window is passed through to SRAM as active-low control strobes.
//   The CPU bus is split into data_in/data_out/data_oe; the top level drives the shared inout bus through the transceiver.
// PARAMETERS
//   ADDR_W    16       CPU address width
//   DATA_W    16       CPU data width
//   IO_BASE   16'hFFF0 base of I/O window; low 4 bits must be 0; window = IO_BASE..IO_BASE+15
//   N_OUT     2        number of output registers
//   OUT_W     10       width of each output register (<= DATA_W)
//   N_IN      2        number of input ports
//   IN_W      10       width of each input port (<= DATA_W)
//   IN_INV    2'b00    per-port invert of raw input (1 = active-low pins)
//   DEBOUNCE  50000    consecutive equal samples required to accept a new level (>= 2)
//   Legality: N_OUT + 2*N_IN + 1 <= 16, N_IN <= DATA_W
// PORTS
//   clk       in   1              system clock, rising edge
//   reset     in   1              synchronous reset, active-low
//   cpu_we    in   1              1 = CPU store, 0 = CPU load
//   addr      in   ADDR_W         CPU address
//   data_in   in   DATA_W         store data from CPU
//   in_pins   in   N_IN*IN_W      raw asynchronous inputs, port p = bits [p*IN_W +: IN_W]
//   data_out  out  DATA_W         load data to CPU
//   data_oe   out  1              1 = controller drives CPU bus
//   out_regs  out  N_OUT*OUT_W    output register contents, port p = bits [p*OUT_W +: OUT_W]
//   mem_ctrl  out  5              {we_n, ce_n, oe_n, lb_n, ub_n} to SRAM
//   irq       out  1              registered interrupt request
// BEHAVIOUR
//   Address map, offset = addr - IO_BASE:
//     0..N_OUT-1                    OUT[p]   RW
//     N_OUT..N_OUT+N_IN-1           IN[p]    RO, debounced level
//     N_OUT+N_IN..N_OUT+2N_IN-1     EDGE[p]  RO with write-1-to-clear, per-bit sticky rising-edge flags
//     N_OUT+2N_IN                   MASK     RW, N_IN bits, per-port irq enable
//     remaining offsets             unmapped: read 0, writes ignored
//   Decode and read path are combinational, so a load completes in the same cycle.
//     In window: mem_ctrl = 5'b11111 (SRAM deselected).
//     data_oe = ~cpu_we; data_out = addressed register, zero-extended to DATA_W.
//   Outside window: data_oe = 0, data_out = 0.
//     Store: mem_ctrl = 5'b00000 (oe_n ignored by SRAM during write).
//     Load:  mem_ctrl = 5'b10000.
//   Stores to OUT/MASK take effect at the next rising edge; low OUT_W/N_IN bits of data_in are used.
//   Input path per port:
//     raw ^ {IN_W{IN_INV[p]}} -> 2-FF synchroniser -> debouncer.
//     Debouncer: a counter of width clog2(DEBOUNCE+1) resets whenever sync != candidate sample.
//     When sync has equalled the candidate for DEBOUNCE consecutive cycles, the debounced level <= candidate.
//     Raw-pin to IN-register latency = 2 + DEBOUNCE cycles minimum.
//   EDGE[p][b] is set when debounced level bit b goes 0->1.
//     Cleared by a store to EDGE[p] with a 1 in bit b.
//     Same-cycle set and clear: set wins.
//   irq <= |(MASK[p] & |EDGE[p]) over all ports; irq is registered, one cycle after the flag/mask change.
//   Reset (reset==0 at a rising edge) clears: OUT, MASK, EDGE, synchronisers, debounced levels, counters, irq.
//     A reset mid-debounce discards the pending candidate.
//   Reset does not gate the combinational decode; mem_ctrl stays address-driven.
// TESTING
//   Use DEBOUNCE=4 on the bench.
//   1 Store 16'h03FF to FFF0, then load FFF0 -> out_regs[9:0]=10'h3FF one edge later; data_out=16'h03FF, data_oe=1, mem_ctrl=5'b11111.
//   2 Load 16'h1234 -> mem_ctrl=5'b10000, data_oe=0.
//     Store 16'h1234 -> mem_ctrl=5'b00000; no change to out_regs.
//   3 Pulse in_pins bit0 high for 3 cycles -> IN0 and EDGE0 stay 0.
//     Hold it high 8 cycles -> IN0=1 exactly 6 cycles after the rise, then EDGE0=16'h0001.
//   4 MASK=1, edge on port0 -> irq=1 one cycle after EDGE0 sets.
//     Store 1 to FFF4 -> EDGE0=0, irq=0 next cycle.
//     Clear coincident with a new edge -> flag stays 1.
//   5 Drive reset=0 for one edge while out/mask/edge are nonzero and a debounce is in progress -> all read 0 and irq=0 next cycle.
//   6 Load unmapped FFF9 -> data_out=0, data_oe=1, mem_ctrl=5'b11111.
//     Store to FFF9 -> no register changes.

Source files
------------

// File: rtl/mmio_io_controller_if.sv
// CPU data-port bus between the single-cycle core and the MMIO controller.
// The shared inout data bus is resolved at the top level from data_out/data_oe.
interface mmio_io_controller_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              cpu_we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              data_oe;

    modport master (
        output cpu_we, addr, data_in,
        input  data_out, data_oe
    );

    modport slave (
        input  cpu_we, addr, data_in,
        output data_out, data_oe
    );
endinterface

// File: rtl/mmio_io_controller.sv
// Memory-mapped I/O controller: 16-word window of output, debounced input, edge-flag and
// mask registers at IO_BASE; all other addresses pass through to SRAM strobes.
module mmio_io_controller #(
    parameter int              ADDR_W   = 16,
    parameter int              DATA_W   = 16,
    parameter logic [ADDR_W-1:0] IO_BASE = 16'hFFF0,
    parameter int              N_OUT    = 2,
    parameter int              OUT_W    = 10,
    parameter int              N_IN     = 2,
    parameter int              IN_W     = 10,
    parameter logic [N_IN-1:0] IN_INV   = 2'b00,
    parameter int              DEBOUNCE = 50000
) (
    input  logic                   clk,
    input  logic                   reset,
    mmio_io_controller_if.slave    bus,
    input  logic [N_IN*IN_W-1:0]   in_pins,
    output logic [N_OUT*OUT_W-1:0] out_regs,
    output logic [4:0]             mem_ctrl,
    output logic                   irq
);

    localparam int OFF_IN   = N_OUT;
    localparam int OFF_EDGE = N_OUT + N_IN;
    localparam int OFF_MASK = N_OUT + 2 * N_IN;
    localparam int CNT_W    = $clog2(DEBOUNCE + 1);

    logic              in_win;
    logic [3:0]        off;
    logic              wr_en;
    logic [DATA_W-1:0] rdata;
    logic              unused_data;

    logic [OUT_W-1:0] out_q [N_OUT];
    logic [N_IN-1:0]  mask_q;
    logic [N_IN-1:0]  edge_any;

    logic [IN_W-1:0]  sync1_q [N_IN];
    logic [IN_W-1:0]  sync2_q [N_IN];
    logic [IN_W-1:0]  cand_q  [N_IN];
    logic [IN_W-1:0]  level_q [N_IN];
    logic [IN_W-1:0]  edge_q  [N_IN];
    logic [CNT_W-1:0] cnt_q   [N_IN];

    logic [IN_W-1:0]  cand_d  [N_IN];
    logic [IN_W-1:0]  level_d [N_IN];
    logic [IN_W-1:0]  edge_d  [N_IN];
    logic [IN_W-1:0]  clr     [N_IN];
    logic [CNT_W-1:0] cnt_d   [N_IN];

    assign in_win      = (bus.addr[ADDR_W-1:4] == IO_BASE[ADDR_W-1:4]);
    assign off         = bus.addr[3:0];
    assign wr_en       = in_win & bus.cpu_we;
    assign unused_data = ^bus.data_in;

    // SRAM strobes {we_n, ce_n, oe_n, lb_n, ub_n}; decode is independent of reset.
    always_comb begin
        mem_ctrl     = 5'b11111;
        bus.data_oe  = 1'b0;
        bus.data_out = '0;
        if (in_win) begin
            bus.data_oe  = ~bus.cpu_we;
            bus.data_out = rdata;
        end else if (bus.cpu_we) begin
            mem_ctrl = 5'b00000;
        end else begin
            mem_ctrl = 5'b10000;
        end
    end

    always_comb begin
        rdata = '0;
        for (int unsigned p = 0; p < N_OUT; p++)
            if (off == 4'(p)) rdata = DATA_W'(out_q[p]);
        for (int unsigned p = 0; p < N_IN; p++) begin
            if (off == 4'(OFF_IN + p))   rdata = DATA_W'(level_q[p]);
            if (off == 4'(OFF_EDGE + p)) rdata = DATA_W'(edge_q[p]);
        end
        if (off == 4'(OFF_MASK)) rdata = DATA_W'(mask_q);
    end

    always_comb begin
        out_regs = '0;
        for (int unsigned p = 0; p < N_OUT; p++)
            out_regs[p*OUT_W +: OUT_W] = out_q[p];
    end

    // Counter holds the run length of equal samples including the current one, so the
    // level is accepted on the DEBOUNCE-th consecutive sample.
    always_comb begin
        for (int unsigned p = 0; p < N_IN; p++) begin
            cand_d[p]  = cand_q[p];
            cnt_d[p]   = cnt_q[p];
            level_d[p] = level_q[p];
            if (sync2_q[p] != cand_q[p]) begin
                cand_d[p] = sync2_q[p];
                cnt_d[p]  = CNT_W'(1);
            end else begin
                if (cnt_q[p] >= CNT_W'(DEBOUNCE - 1)) level_d[p] = cand_q[p];
                if (cnt_q[p] != CNT_W'(DEBOUNCE))     cnt_d[p]   = cnt_q[p] + CNT_W'(1);
            end
            clr[p]      = (wr_en && off == 4'(OFF_EDGE + p)) ? bus.data_in[IN_W-1:0] : '0;
            edge_d[p]   = (edge_q[p] & ~clr[p]) | (level_d[p] & ~level_q[p]);
            edge_any[p] = |edge_q[p];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned p = 0; p < N_OUT; p++) out_q[p] <= '0;
            for (int unsigned p = 0; p < N_IN; p++) begin
                sync1_q[p] <= '0;
                sync2_q[p] <= '0;
                cand_q[p]  <= '0;
                level_q[p] <= '0;
                edge_q[p]  <= '0;
                cnt_q[p]   <= '0;
            end
            mask_q <= '0;
            irq    <= 1'b0;
        end else begin
            for (int unsigned p = 0; p < N_OUT; p++)
                if (wr_en && off == 4'(p)) out_q[p] <= bus.data_in[OUT_W-1:0];
            if (wr_en && off == 4'(OFF_MASK)) mask_q <= bus.data_in[N_IN-1:0];
            for (int unsigned p = 0; p < N_IN; p++) begin
                sync1_q[p] <= in_pins[p*IN_W +: IN_W] ^ {IN_W{IN_INV[p]}};
                sync2_q[p] <= sync1_q[p];
                cand_q[p]  <= cand_d[p];
                cnt_q[p]   <= cnt_d[p];
                level_q[p] <= level_d[p];
                edge_q[p]  <= edge_d[p];
            end
            irq <= |(mask_q & edge_any);
        end
    end

endmodule
